// File: rtl/pt_cache_sched_pkg.sv
// pt_cache_pkg: shared definitions for the page-table cache scheduler.
// Holds the cache command encodings, the scheduler FSM state encoding,
// the per-transaction strobe count and a one-hot helper.
package pt_cache_pkg;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_LD  = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WSTB,
    S_WLOW,
    S_RWAIT,
    S_LWAIT,
    S_FIN,
    S_NOPGAP
  } state_t;

  // 16 PT bytes + 4 PTE bytes + 1 PID byte per WR/LD transaction
  localparam int NBYTES = 21;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pt_cache_sched_if.sv
// pt_cache_sched_if: command/strobe bus between the scheduler and the
// page-table cache.
//   c_cmd, c_datavalid, c_datain, c_pid : scheduler -> cache
//   c_pagefault, c_outvalid, c_dataout  : cache -> scheduler status/data
//   c_wd                                : cache write-done (monitored only)
// master = scheduler side, slave = cache side.
interface pt_cache_sched_if;
  import pt_cache_pkg::*;

  cmd_t       c_cmd;
  logic       c_datavalid;
  logic [7:0] c_datain;
  logic [3:0] c_pid;
  logic       c_pagefault;
  logic       c_outvalid;
  logic [7:0] c_dataout;
  logic       c_wd;

  modport master (
    output c_cmd, c_datavalid, c_datain, c_pid,
    input  c_pagefault, c_outvalid, c_dataout, c_wd
  );

  modport slave (
    input  c_cmd, c_datavalid, c_datain, c_pid,
    output c_pagefault, c_outvalid, c_dataout, c_wd
  );
endinterface

// File: rtl/pt_cache_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid[1:0] : qualified requests
//   update     : the current grant has been taken; remember its winner
//   grant[1:0] : one-hot combinational grant (all zero when nobody asks)
// rr_last resets to 1 so port 0 wins the first contest.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant
);

  logic rr_last_reg;

  // The port that did not win last time gets priority.
  always_comb begin
    grant = 2'b00;
    if (rr_last_reg) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      if (valid[1])      grant = 2'b10;
      else if (valid[0]) grant = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_last_reg <= 1'b1;
    else if (update) rr_last_reg <= grant[1];
  end

endmodule

// File: rtl/pt_cache_sched.sv
// pt_cache_sched: shares the page-table cache between two requesters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req, op0/1, pid0/1,
//   addr0/1, wdata0/1     : requester commands, held while req is high
//   pull                  : WR byte consumed, present the next one
//   gnt, done, rvalid,
//   resp_data, fault, tout: per-requester grant/completion/result
//   cbus                  : cache command/strobe bus (master side)
// All outputs are registered. Each transaction runs IDLE -> SETUP ->
// (WSTB/WLOW | RWAIT | LWAIT) -> FIN -> NOPGAP -> IDLE.
module pt_cache_sched
  import pt_cache_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int GAP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [3:0] pid0,
  input  logic [3:0] pid1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] pull,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [1:0] rvalid,
  output logic [7:0] resp_data,
  output logic       fault,
  output logic       tout,
  pt_cache_sched_if.master cbus
);

  localparam logic [4:0] NB5      = 5'(NBYTES);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  // done lands two cycles after the abort decision (FIN + output register),
  // so deciding at TIMEOUT-2 puts done exactly TIMEOUT cycles after the
  // last rvalid pulse (or after the first wait cycle).
  localparam logic [6:0] TO_LAST  = 7'(TIMEOUT - 2);

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;
  cmd_t       op_reg, op_next;
  logic [3:0] pid_reg, pid_next;
  logic [7:0] addr_reg, addr_next;
  logic [4:0] beat_reg, beat_next;
  logic [6:0] tcnt_reg, tcnt_next;
  logic [3:0] gap_reg, gap_next;
  logic       flt_reg, flt_next;
  logic       to_reg, to_next;
  logic       ov_prev_reg, ov_prev_next;
  logic [1:0] gnt_reg, gnt_next, done_reg, done_next;
  logic [1:0] rvalid_reg, rvalid_next, pull_reg, pull_next;
  logic [7:0] resp_reg, resp_next;
  logic       fault_reg, fault_next, tout_reg, tout_next;
  cmd_t       cmd_reg, cmd_next;
  logic       dv_reg, dv_next;
  logic [7:0] din_reg, din_next;
  logic [3:0] cpid_reg, cpid_next;

  logic [1:0] req_valid, arb_gnt;
  logic       arb_take;
  logic       unused_wd;

  assign unused_wd    = cbus.c_wd;
  // op=00 is not a request
  assign req_valid[0] = req[0] && (op0 != 2'b00);
  assign req_valid[1] = req[1] && (op1 != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (req_valid),
    .update (arb_take),
    .grant  (arb_gnt)
  );

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    op_next      = op_reg;
    pid_next     = pid_reg;
    addr_next    = addr_reg;
    beat_next    = beat_reg;
    tcnt_next    = tcnt_reg;
    gap_next     = gap_reg;
    flt_next     = flt_reg;
    to_next      = to_reg;
    ov_prev_next = cbus.c_outvalid;
    gnt_next     = gnt_reg;
    done_next    = 2'b00;
    rvalid_next  = 2'b00;
    pull_next    = 2'b00;
    resp_next    = resp_reg;
    fault_next   = 1'b0;
    tout_next    = 1'b0;
    cmd_next     = cmd_reg;
    dv_next      = 1'b0;
    din_next     = din_reg;
    cpid_next    = cpid_reg;
    arb_take     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (arb_gnt != 2'b00) begin
          arb_take   = 1'b1;
          owner_next = arb_gnt[1];
          gnt_next   = arb_gnt;
          op_next    = cmd_t'(arb_gnt[1] ? op1 : op0);
          pid_next   = arb_gnt[1] ? pid1 : pid0;
          addr_next  = arb_gnt[1] ? addr1 : addr0;
          beat_next  = 5'd0;
          flt_next   = 1'b0;
          to_next    = 1'b0;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        cmd_next  = op_reg;
        cpid_next = pid_reg;
        tcnt_next = 7'd0;
        case (op_reg)
          CMD_WR:  state_next = S_WSTB;
          CMD_RD: begin
            din_next   = addr_reg;
            state_next = S_RWAIT;
          end
          default: state_next = S_LWAIT;
        endcase
      end
      S_WSTB: begin
        din_next   = owner_reg ? wdata1 : wdata0;
        dv_next    = 1'b1;
        pull_next  = port_onehot(owner_reg);
        if (beat_reg != NB5) beat_next = beat_reg + 5'd1;
        state_next = S_WLOW;
      end
      S_WLOW: begin
        state_next = (beat_reg < NB5) ? S_WSTB : S_FIN;
      end
      S_RWAIT: begin
        // page fault takes precedence over a simultaneous outvalid
        if (cbus.c_pagefault) begin
          flt_next   = 1'b1;
          state_next = S_FIN;
        end else if (cbus.c_outvalid) begin
          resp_next   = cbus.c_dataout;
          rvalid_next = port_onehot(owner_reg);
          state_next  = S_FIN;
        end else if (tcnt_reg == TO_LAST) begin
          to_next    = 1'b1;
          state_next = S_FIN;
        end else begin
          tcnt_next = tcnt_reg + 7'd1;
        end
      end
      S_LWAIT: begin
        // one byte per rising edge of c_outvalid
        if (cbus.c_outvalid && !ov_prev_reg) begin
          resp_next   = cbus.c_dataout;
          rvalid_next = port_onehot(owner_reg);
          tcnt_next   = 7'd0;
          if (beat_reg != NB5)        beat_next  = beat_reg + 5'd1;
          if (beat_reg == NB5 - 5'd1) state_next = S_FIN;
        end else if (tcnt_reg == TO_LAST) begin
          to_next    = 1'b1;
          state_next = S_FIN;
        end else begin
          tcnt_next = tcnt_reg + 7'd1;
        end
      end
      S_FIN: begin
        done_next  = port_onehot(owner_reg);
        fault_next = flt_reg;
        tout_next  = to_reg;
        gnt_next   = 2'b00;
        cmd_next   = CMD_NOP;
        gap_next   = 4'd0;
        state_next = S_NOPGAP;
      end
      S_NOPGAP: begin
        if (gap_reg == GAP_LAST) state_next = S_IDLE;
        else                     gap_next   = gap_reg + 4'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      owner_reg   <= 1'b0;
      op_reg      <= CMD_NOP;
      pid_reg     <= 4'd0;
      addr_reg    <= 8'd0;
      beat_reg    <= 5'd0;
      tcnt_reg    <= 7'd0;
      gap_reg     <= 4'd0;
      flt_reg     <= 1'b0;
      to_reg      <= 1'b0;
      ov_prev_reg <= 1'b0;
      gnt_reg     <= 2'b00;
      done_reg    <= 2'b00;
      rvalid_reg  <= 2'b00;
      pull_reg    <= 2'b00;
      resp_reg    <= 8'd0;
      fault_reg   <= 1'b0;
      tout_reg    <= 1'b0;
      cmd_reg     <= CMD_NOP;
      dv_reg      <= 1'b0;
      din_reg     <= 8'd0;
      cpid_reg    <= 4'd0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      op_reg      <= op_next;
      pid_reg     <= pid_next;
      addr_reg    <= addr_next;
      beat_reg    <= beat_next;
      tcnt_reg    <= tcnt_next;
      gap_reg     <= gap_next;
      flt_reg     <= flt_next;
      to_reg      <= to_next;
      ov_prev_reg <= ov_prev_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      rvalid_reg  <= rvalid_next;
      pull_reg    <= pull_next;
      resp_reg    <= resp_next;
      fault_reg   <= fault_next;
      tout_reg    <= tout_next;
      cmd_reg     <= cmd_next;
      dv_reg      <= dv_next;
      din_reg     <= din_next;
      cpid_reg    <= cpid_next;
    end
  end

  assign gnt              = gnt_reg;
  assign done             = done_reg;
  assign rvalid           = rvalid_reg;
  assign pull             = pull_reg;
  assign resp_data        = resp_reg;
  assign fault            = fault_reg;
  assign tout             = tout_reg;
  assign cbus.c_cmd       = cmd_reg;
  assign cbus.c_datavalid = dv_reg;
  assign cbus.c_datain    = din_reg;
  assign cbus.c_pid       = cpid_reg;

endmodule

// File: tb/tb_pt_cache_sched.sv
// tb_pt_cache_sched: directed bench for pt_cache_sched. The cache is
// modelled by hand in the stimulus sequence; expected values are constants.
module tb_pt_cache_sched;
  import pt_cache_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, op0, op1;
  logic [3:0] pid0, pid1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] pull, gnt, done, rvalid;
  logic [7:0] resp_data;
  logic       fault, tout;

  int checks = 0;
  int failures = 0;

  pt_cache_sched_if cbus();

  pt_cache_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op0       (op0),
    .op1       (op1),
    .pid0      (pid0),
    .pid1      (pid1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .pull      (pull),
    .gnt       (gnt),
    .done      (done),
    .rvalid    (rvalid),
    .resp_data (resp_data),
    .fault     (fault),
    .tout      (tout),
    .cbus      (cbus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int         dv_cnt, pull_cnt, bad_strobe, seq_bad, bad_pull1;
  int         rv_cnt, data_bad, last_rv, done_cyc, sent;
  logic       dv_prev, found, flt_v, to_v;
  logic [1:0] done_val, gnt_exp;
  logic [7:0] rdata;
  cmd_t       cmd_first, cmd_at_done;
  logic [3:0] pid_first;

  initial begin
    rst_n = 1'b0; req = 2'b00; op0 = 2'b00; op1 = 2'b00;
    pid0 = 4'h0; pid1 = 4'h0; addr0 = 8'h00; addr1 = 8'h00;
    wdata0 = 8'h00; wdata1 = 8'h00;
    cbus.c_pagefault = 1'b0; cbus.c_outvalid = 1'b0;
    cbus.c_dataout = 8'h00; cbus.c_wd = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_cmd", cbus.c_cmd, CMD_NOP);
    chk("rst_dv", cbus.c_datavalid, 1'b0);
    chk("rst_pull_rvalid", {pull, rvalid}, 4'b0000);
    chk("rst_fault_tout", {fault, tout}, 2'b00);
    rst_n = 1'b1;

    // both request right after reset: port 0 WR first, then port 1 RD
    @(negedge clk);
    op0 = 2'b10; pid0 = 4'h2; wdata0 = 8'h00;
    op1 = 2'b01; pid1 = 4'h7; addr1 = 8'hC5;
    req = 2'b11;
    dv_cnt = 0; pull_cnt = 0; bad_strobe = 0; seq_bad = 0; bad_pull1 = 0;
    dv_prev = 1'b0; found = 1'b0;
    cmd_first = CMD_NOP; pid_first = 4'h0; cmd_at_done = CMD_WR;
    for (int cyc = 0; cyc < 120 && !found; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("wr_first_gnt", gnt, 2'b01);
      if (cbus.c_datavalid) begin
        if (dv_prev) bad_strobe++;
        if (dv_cnt == 0) begin cmd_first = cbus.c_cmd; pid_first = cbus.c_pid; end
        if (cbus.c_datain !== dv_cnt[7:0]) seq_bad++;
        dv_cnt++;
      end
      dv_prev = cbus.c_datavalid;
      if (pull[1]) bad_pull1++;
      if (pull[0]) begin pull_cnt++; wdata0 = wdata0 + 8'd1; end
      if (done != 2'b00) begin
        found = 1'b1; done_val = done; flt_v = fault; to_v = tout;
        cmd_at_done = cbus.c_cmd; req[0] = 1'b0;
      end
    end
    chk("wr_done_seen", found, 1'b1);
    chk("wr_done_port", done_val, 2'b01);
    chk("wr_strobes", dv_cnt, 21);
    chk("wr_strobe_shape", bad_strobe, 0);
    chk("wr_data_seq", seq_bad, 0);
    chk("wr_pulls", pull_cnt, 21);
    chk("wr_pull1", bad_pull1, 0);
    chk("wr_cmd", cmd_first, CMD_WR);
    chk("wr_pid", pid_first, 4'h2);
    chk("wr_fault_tout", {flt_v, to_v}, 2'b00);
    chk("wr_nop_at_done", cmd_at_done, CMD_NOP);
    $display("TXN wr port0 strobes=%0d pulls=%0d", dv_cnt, pull_cnt);
    @(negedge clk);
    chk("wr_gap2_cmd", cbus.c_cmd, CMD_NOP);
    chk("wr_gap2_gnt_done", {gnt, done}, 4'b0000);

    // port 1 RD, cache answers 3C
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (cbus.c_cmd === CMD_RD) found = 1'b1;
    end
    chk("rd_start", found, 1'b1);
    chk("rd_gnt", gnt, 2'b10);
    chk("rd_addr", cbus.c_datain, 8'hC5);
    chk("rd_pid", cbus.c_pid, 4'h7);
    cbus.c_outvalid = 1'b1; cbus.c_dataout = 8'h3C;
    @(negedge clk);
    cbus.c_outvalid = 1'b0;
    chk("rd_rvalid", rvalid, 2'b10);
    chk("rd_data", resp_data, 8'h3C);
    chk("rd_done_not_yet", done, 2'b00);
    @(negedge clk);
    chk("rd_done", done, 2'b10);
    chk("rd_fault_tout", {fault, tout}, 2'b00);
    req[1] = 1'b0;
    $display("TXN rd port1 data=%0h", 8'h3C);

    // both request RD repeatedly: grants alternate 0,1,0,1; the first
    // gets a page fault with outvalid high in the same cycle
    @(negedge clk);
    op0 = 2'b01; op1 = 2'b01; pid0 = 4'h3; pid1 = 4'h9;
    addr0 = 8'h11; addr1 = 8'h22; req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      gnt_exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      found = 1'b0;
      for (int w = 0; w < 40 && !found; w++) begin
        @(negedge clk);
        if (cbus.c_cmd === CMD_RD) found = 1'b1;
      end
      chk("alt_start", found, 1'b1);
      chk("alt_gnt", gnt, gnt_exp);
      if (t == 0) begin
        cbus.c_pagefault = 1'b1; cbus.c_outvalid = 1'b1; cbus.c_dataout = 8'hEE;
      end else begin
        cbus.c_outvalid = 1'b1; cbus.c_dataout = 8'h10 + 8'(t);
      end
      found = 1'b0; rv_cnt = 0; rdata = 8'h00;
      for (int w = 0; w < 8 && !found; w++) begin
        @(negedge clk);
        cbus.c_pagefault = 1'b0; cbus.c_outvalid = 1'b0;
        if (rvalid != 2'b00) begin rv_cnt++; rdata = resp_data; end
        if (done != 2'b00) begin found = 1'b1; done_val = done; flt_v = fault; to_v = tout; end
      end
      chk("alt_done_seen", found, 1'b1);
      chk("alt_done_port", done_val, gnt_exp);
      chk("alt_fault", flt_v, (t == 0) ? 1'b1 : 1'b0);
      chk("alt_tout", to_v, 1'b0);
      chk("alt_rvalid_cnt", rv_cnt, (t == 0) ? 0 : 1);
      if (t != 0) chk("alt_data", rdata, 8'h10 + 8'(t));
      $display("TXN rd alt t=%0d gnt=%b fault=%b rvalids=%0d", t, done_val, flt_v, rv_cnt);
    end

    // LD on port 0 with only 10 responses, then timeout
    req = 2'b01; op0 = 2'b11; pid0 = 4'h5;
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clk);
      if (cbus.c_cmd === CMD_LD) found = 1'b1;
    end
    chk("ld_start", found, 1'b1);
    found = 1'b0; sent = 0; rv_cnt = 0; data_bad = 0; last_rv = -1; done_cyc = -1;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      if (rvalid[0]) begin
        if (resp_data !== 8'hA0 + rv_cnt[7:0]) data_bad++;
        rv_cnt++; last_rv = cyc;
      end
      if (done != 2'b00) begin
        found = 1'b1; done_val = done; flt_v = fault; to_v = tout; done_cyc = cyc;
        req[0] = 1'b0;
      end
      if (sent < 10 && cyc % 3 == 0) begin
        cbus.c_outvalid = 1'b1; cbus.c_dataout = 8'hA0 + sent[7:0]; sent++;
      end else begin
        cbus.c_outvalid = 1'b0;
      end
    end
    cbus.c_outvalid = 1'b0;
    chk("ld_done_seen", found, 1'b1);
    chk("ld_rvalid_cnt", rv_cnt, 10);
    chk("ld_data", data_bad, 0);
    chk("ld_done_port", done_val, 2'b01);
    chk("ld_tout_fault", {to_v, flt_v}, 2'b10);
    chk("ld_timeout_gap", done_cyc - last_rv, 64);
    $display("TXN ld port0 bytes=%0d gap=%0d tout=%b", rv_cnt, done_cyc - last_rv, to_v);
    @(negedge clk);
    chk("ld_tout_cleared", {fault, tout}, 2'b00);

    // WR on port 0 interrupted by reset
    op0 = 2'b10; wdata0 = 8'h55; req = 2'b01; dv_cnt = 0;
    for (int w = 0; w < 80 && dv_cnt < 3; w++) begin
      @(negedge clk);
      if (cbus.c_datavalid) dv_cnt++;
    end
    chk("rst_wr_started", dv_cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", gnt, 2'b00);
    chk("rst_mid_cmd", cbus.c_cmd, CMD_NOP);
    chk("rst_mid_bus", {cbus.c_datavalid, cbus.c_datain, cbus.c_pid}, 13'h0);
    chk("rst_mid_outs", {pull, done, rvalid, resp_data, fault, tout}, 16'h0);
    $display("TXN reset mid-wr after %0d strobes", dv_cnt);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {gnt, cbus.c_cmd}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
